// File: rtl/fb_line_drawer_if.sv
// ---------------------------------------------------------------------------
// fb_line_drawer_if
//   Bundles the command handshake of the line/clear drawing engine and the
//   RAM write port it drives into one interface.
//
//   Command side (driven by master, sampled by the engine):
//     cmd_valid       command present this cycle
//     cmd_clear       1 = clear whole buffer, 0 = draw line
//     x0, x1          line endpoint x (9 bit, unsigned)
//     y0, y1          line endpoint y (8 bit, unsigned)
//     color           pixel value written
//   Engine side (driven by the engine / slave):
//     cmd_ready       engine idle, command accepted on cmd_valid & cmd_ready
//     busy            command in progress (inverse of cmd_ready)
//     done            one-cycle pulse after the last write of a command
//     write_address   RAM write address
//     ram_in          RAM write data
//     we              RAM write enable
// ---------------------------------------------------------------------------
interface fb_line_drawer_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_clear;
  logic [8:0]            x0;
  logic [8:0]            x1;
  logic [7:0]            y0;
  logic [7:0]            y1;
  logic                  color;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] write_address;
  logic                  ram_in;
  logic                  we;

  modport master (
    output cmd_valid, cmd_clear, x0, x1, y0, y1, color,
    input  cmd_ready, busy, done, write_address, ram_in, we
  );

  modport slave (
    input  cmd_valid, cmd_clear, x0, x1, y0, y1, color,
    output cmd_ready, busy, done, write_address, ram_in, we
  );
endinterface

// File: rtl/fb_line_drawer.sv
// ---------------------------------------------------------------------------
// fb_line_drawer
//   Drawing engine in front of the 1-bpp framebuffer RAM. Accepts line and
//   clear commands and issues at most one RAM write per clock. Lines are
//   rasterised with integer Bresenham; clear walks every framebuffer address
//   in ascending order. Pixels outside the framebuffer still take their cycle
//   but are never written.
//
//   Ports:
//     clk     system clock (shared with the framebuffer RAM)
//     reset   synchronous, active-high reset
//     bus     fb_line_drawer_if.slave: command handshake and RAM write port
//             (write_address / ram_in / we are registered outputs)
// ---------------------------------------------------------------------------
module fb_line_drawer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic            clk,
  input  logic            reset,
  fb_line_drawer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
  // One bit wider than the coordinates so a full 512/256 extent still compares correctly.
  localparam logic [9:0]            X_LIMIT    = 10'(FB_WIDTH);
  localparam logic [8:0]            Y_LIMIT    = 9'(FB_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    CLEAR
  } state_t;

  state_t state, state_next;

  logic                  ready;
  logic                  accept;

  // Latched command and Bresenham working set.
  logic [8:0]            cur_x, end_x;
  logic [7:0]            cur_y, end_y;
  logic                  pen;
  logic signed [10:0]    dx, dy, err;
  logic                  step_left, step_up;

  // Registered RAM port and status.
  logic                  we_q, ram_in_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Combinational datapath helpers.
  logic                  at_end, clear_end;
  logic [8:0]            abs_dx;
  logic [7:0]            abs_dy;
  logic signed [10:0]    setup_dx, setup_dy;
  logic signed [11:0]    e2, dx_w, dy_w;
  logic                  move_x, move_y;
  logic signed [10:0]    err_step;
  logic [8:0]            next_x, pt_x;
  logic [7:0]            next_y, pt_y;
  logic                  pt_in;
  logic [ADDR_WIDTH-1:0] pt_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs. A command is only taken while idle;
  // anything presented while busy is dropped rather than queued.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.cmd_valid;
        if (bus.cmd_valid) state_next = bus.cmd_clear ? CLEAR : SETUP;
      end
      SETUP: state_next = DRAW;
      DRAW:  if (at_end) state_next = IDLE;
      CLEAR: if (clear_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bresenham arithmetic. e2 = 2*err needs one extra bit; the x and y
  // decisions both use the same e2 so both error increments apply together.
  always_comb begin
    at_end    = (cur_x == end_x) && (cur_y == end_y);
    clear_end = (addr_q == LAST_ADDR);

    abs_dx    = (end_x >= cur_x) ? (end_x - cur_x) : (cur_x - end_x);
    abs_dy    = (end_y >= cur_y) ? (end_y - cur_y) : (cur_y - end_y);
    setup_dx  = signed'({2'b00, abs_dx});
    setup_dy  = -signed'({3'b000, abs_dy});

    e2        = {err, 1'b0};
    dx_w      = 12'(dx);
    dy_w      = 12'(dy);
    move_x    = (e2 >= dy_w);
    move_y    = (e2 <= dx_w);
    err_step  = err + (move_x ? dy : 11'sd0) + (move_y ? dx : 11'sd0);

    next_x    = cur_x;
    next_y    = cur_y;
    if (move_x) next_x = step_left ? (cur_x - 9'd1) : (cur_x + 9'd1);
    if (move_y) next_y = step_up   ? (cur_y - 8'd1) : (cur_y + 8'd1);

    // SETUP registers the first endpoint; DRAW registers the following point.
    pt_x      = (state == SETUP) ? cur_x : next_x;
    pt_y      = (state == SETUP) ? cur_y : next_y;
    pt_in     = ({1'b0, pt_x} < X_LIMIT) && ({1'b0, pt_y} < Y_LIMIT);
    pt_addr   = ADDR_WIDTH'(pt_y) * ROW_STRIDE + ADDR_WIDTH'(pt_x);
  end

  // Datapath and registered RAM port. The write registers are loaded on the
  // edge entering the cycle they describe, so each DRAW/CLEAR cycle presents
  // its own pixel. Address and data only move when a write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      ram_in_q  <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      end_x     <= '0;
      end_y     <= '0;
      pen       <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      step_left <= 1'b0;
      step_up   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          if (accept) begin
            cur_x <= bus.x0;
            cur_y <= bus.y0;
            end_x <= bus.x1;
            end_y <= bus.y1;
            pen   <= bus.color;
            if (bus.cmd_clear) begin
              we_q     <= 1'b1;
              addr_q   <= '0;
              ram_in_q <= bus.color;
            end
          end
        end
        SETUP: begin
          dx        <= setup_dx;
          dy        <= setup_dy;
          err       <= setup_dx + setup_dy;
          step_left <= (end_x < cur_x);
          step_up   <= (end_y < cur_y);
          we_q      <= pt_in;
          if (pt_in) begin
            addr_q   <= pt_addr;
            ram_in_q <= pen;
          end
        end
        DRAW: begin
          if (at_end) begin
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cur_x <= next_x;
            cur_y <= next_y;
            err   <= err_step;
            we_q  <= pt_in;
            if (pt_in) begin
              addr_q   <= pt_addr;
              ram_in_q <= pen;
            end
          end
        end
        CLEAR: begin
          if (clear_end) begin
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  assign bus.cmd_ready     = ready;
  assign bus.busy          = ~ready;
  assign bus.done          = done_q;
  assign bus.we            = we_q;
  assign bus.ram_in        = ram_in_q;
  assign bus.write_address = addr_q;

endmodule

// File: tb/tb_fb_line_drawer.sv
// ---------------------------------------------------------------------------
// tb_fb_line_drawer
//   Self-checking bench for fb_line_drawer. Each accepted command is expanded
//   by a software model into the exact per-cycle expectation (we, address,
//   data, done, ready) which one compare process checks every clock. A set of
//   hand-computed literals pins the model and the DUT timing.
// ---------------------------------------------------------------------------
module tb_fb_line_drawer;

  localparam int W     = 320;
  localparam int H     = 240;
  localparam int AW    = 17;
  localparam int NPIX  = W * H;

  typedef struct packed {
    logic          we;
    logic          done;
    logic          ready;
    logic [AW-1:0] addr;
    logic          data;
  } exp_t;

  typedef struct {
    int cyc;
    int addr;
    bit data;
  } obs_t;

  logic clk;
  logic reset;

  fb_line_drawer_if #(.ADDR_WIDTH(AW)) bus ();

  fb_line_drawer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t          exp_q[$];
  exp_t          build_q[$];
  obs_t          obs_q[$];
  int            obs_done_cyc;
  logic [AW-1:0] exp_addr;
  logic          exp_data;
  bit            checking;
  int            cyc;
  int            checks;
  int            errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic print_summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
      if (errors >= 50) begin
        print_summary();
        $finish;
      end
    end
  endtask

  // Per-cycle compare: with nothing queued the engine must sit idle with the
  // RAM port holding its last written address and data.
  always @(negedge clk) begin : compare_proc
    exp_t        e;
    logic [31:0] act, want;
    if (checking) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else begin
        e       = '0;
        e.ready = 1'b1;
      end
      if (e.we) begin
        exp_addr = e.addr;
        exp_data = e.data;
      end
      want = {10'd0, e.we, e.done, e.ready, ~e.ready, exp_data, exp_addr};
      act  = {10'd0, bus.we, bus.done, bus.cmd_ready, bus.busy, bus.ram_in, bus.write_address};
      check_output($sformatf("cycle %0d {we,done,ready,busy,data,addr}", cyc), act, want);
      if (bus.we === 1'b1) obs_q.push_back('{cyc, int'(bus.write_address), bus.ram_in});
      if (bus.done === 1'b1) obs_done_cyc = cyc;
    end
  end

  // Line model: SETUP cycle, one cycle per Bresenham point, then the done cycle.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1, input bit c);
    int   x, y, dx, dy, sx, sy, err, e2;
    exp_t e;
    build_q.delete();
    e = '0;
    build_q.push_back(e);
    x   = ax0;
    y   = ay0;
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    for (int k = 0; k < 1024; k++) begin
      e      = '0;
      e.we   = (x < W) && (y < H);
      e.addr = AW'(y * W + x);
      e.data = c;
      build_q.push_back(e);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    e       = '0;
    e.done  = 1'b1;
    e.ready = 1'b1;
    build_q.push_back(e);
  endtask

  task automatic model_clear(input bit c);
    exp_t e;
    build_q.delete();
    for (int a = 0; a < NPIX; a++) begin
      e      = '0;
      e.we   = 1'b1;
      e.addr = AW'(a);
      e.data = c;
      build_q.push_back(e);
    end
    e       = '0;
    e.done  = 1'b1;
    e.ready = 1'b1;
    build_q.push_back(e);
  endtask

  task automatic scribble();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_clear = 1'($urandom);
    bus.x0        = 9'($urandom);
    bus.x1        = 9'($urandom);
    bus.y0        = 8'($urandom);
    bus.y1        = 8'($urandom);
    bus.color     = 1'($urandom);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_done_cyc = -1;
  endtask

  // Random junk (including cmd_valid) is driven while the engine is busy; the
  // done cycle has cmd_ready high, so valid is dropped there.
  task automatic drive_busy(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (exp_q.size() == 0) break;
      if (exp_q.size() == 1) bus.cmd_valid = 1'b0;
      else                   scribble();
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (k == limit) check_output("command completion timeout (pending entries)", exp_q.size(), 0);
  endtask

  // Issues one command in an idle cycle; n returns the acceptance cycle.
  task automatic apply_stimulus(input bit clr, input int ax0, input int ay0, input int ax1,
                                input int ay1, input bit c, output int n);
    n             = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_clear = clr;
    bus.x0        = 9'(ax0);
    bus.y0        = 8'(ay0);
    bus.x1        = 9'(ax1);
    bus.y1        = 8'(ay1);
    bus.color     = c;
    @(posedge clk);
    if (clr) model_clear(c);
    else     model_line(ax0, ay0, ax1, ay1, c);
    foreach (build_q[i]) exp_q.push_back(build_q[i]);
    #1;
    drive_busy(NPIX + 1000);
  endtask

  initial begin : watchdog
    #3000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    print_summary();
    $finish;
  end

  initial begin : main
    int n;
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    checking      = 1'b0;
    exp_addr      = '0;
    exp_data      = 1'b0;
    obs_done_cyc  = -1;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.x0        = '0;
    bus.x1        = '0;
    bus.y0        = '0;
    bus.y1        = '0;
    bus.color     = 1'b0;

    @(posedge clk);
    #1 checking = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] model pins");
    model_line(10, 10, 7, 13, 1);
    check_output("model diag length", build_q.size(), 6);
    check_output("model diag addr0", int'(build_q[1].addr), 3210);
    check_output("model diag addr1", int'(build_q[2].addr), 3529);
    check_output("model diag addr2", int'(build_q[3].addr), 3848);
    check_output("model diag addr3", int'(build_q[4].addr), 4167);
    model_line(318, 0, 321, 0, 1);
    check_output("model clip we pattern",
                 {28'd0, build_q[1].we, build_q[2].we, build_q[3].we, build_q[4].we}, 32'b1100);

    $display("[TB] horizontal line (0,0)-(3,0)");
    clear_obs();
    apply_stimulus(0, 0, 0, 3, 0, 1, n);
    check_output("hline write count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check_output($sformatf("hline addr %0d", i), obs_q[i].addr, i);
      check_output($sformatf("hline cycle %0d", i), obs_q[i].cyc - n, 2 + i);
    end
    check_output("hline done cycle", obs_done_cyc - n, 6);

    $display("[TB] diagonal line (10,10)-(7,13)");
    clear_obs();
    apply_stimulus(0, 10, 10, 7, 13, 1, n);
    check_output("diag write count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check_output("diag addr0", obs_q[0].addr, 3210);
      check_output("diag addr3", obs_q[3].addr, 4167);
      check_output("diag last cycle", obs_q[3].cyc - n, 5);
    end
    check_output("diag done cycle", obs_done_cyc - n, 6);

    $display("[TB] clipped line (318,0)-(321,0)");
    clear_obs();
    apply_stimulus(0, 318, 0, 321, 0, 1, n);
    check_output("clip write count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check_output("clip addr0", obs_q[0].addr, 318);
      check_output("clip addr1", obs_q[1].addr, 319);
    end
    check_output("clip done cycle", obs_done_cyc - n, 6);

    $display("[TB] random lines");
    for (int t = 0; t < 14; t++) begin
      int ax0, ay0, ax1, ay1;
      ax0 = int'($urandom_range(0, 511));
      ay0 = int'($urandom_range(0, 255));
      if (t % 2 == 0) begin
        ax1 = int'($urandom_range(0, 511));
        ay1 = int'($urandom_range(0, 255));
      end else begin
        ax1 = ax0 + int'($urandom_range(0, 24)) - 12;
        ay1 = ay0 + int'($urandom_range(0, 24)) - 12;
        if (ax1 < 0) ax1 = 0;
        if (ax1 > 511) ax1 = 511;
        if (ay1 < 0) ay1 = 0;
        if (ay1 > 255) ay1 = 255;
      end
      apply_stimulus(0, ax0, ay0, ax1, ay1, 1'($urandom), n);
    end

    $display("[TB] full clear to 0");
    clear_obs();
    apply_stimulus(1, 0, 0, 0, 0, 0, n);
    check_output("clear write count", obs_q.size(), NPIX);
    if (obs_q.size() == NPIX) begin
      check_output("clear first addr", obs_q[0].addr, 0);
      check_output("clear first cycle", obs_q[0].cyc - n, 1);
      check_output("clear last addr", obs_q[NPIX-1].addr, NPIX - 1);
    end
    check_output("clear done cycle", obs_done_cyc - n, NPIX + 1);

    $display("[TB] reset during clear");
    clear_obs();
    n             = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_clear = 1'b1;
    bus.color     = 1'b1;
    @(posedge clk);
    model_clear(1);
    foreach (build_q[i]) exp_q.push_back(build_q[i]);
    #1 bus.cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_addr = '0;
    exp_data = 1'b0;
    #1;
    reset = 1'b0;
    check_output("post-reset we", bus.we, 0);
    check_output("post-reset cmd_ready", bus.cmd_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check_output("reset clear write count", obs_q.size(), 41);
    check_output("reset clear no done", obs_done_cyc, -1);

    $display("[TB] point (5,5) after reset");
    clear_obs();
    apply_stimulus(0, 5, 5, 5, 5, 0, n);
    check_output("point write count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check_output("point addr", obs_q[0].addr, 1605);
      check_output("point data", obs_q[0].data, 0);
      check_output("point cycle", obs_q[0].cyc - n, 2);
    end
    check_output("point done cycle", obs_done_cyc - n, 3);

    repeat (4) @(posedge clk);
    #1;
    checking = 1'b0;
    print_summary();
    $finish;
  end

endmodule
